wb_retire_buffer: RTL

- Parametrised successor to the single-entry writeback stage: a DEPTH-entry in-order retire FIFO between MEM and the register file / CSR unit.
- Accepts MEM results with a valid/ready handshake and retires at most one entry per cycle: regfile write, or exception / ertn / refetch flush.
- Provides multi-entry forwarding lookups for ID, replacing the single WB bypass bus.
- Sits at the tail of the pipeline and drives rf write, CSR exception inputs and debug trace.

---
 rtl/wb_retire_buffer_pkg.sv | 90 +++++++++
 rtl/wb_retire_buffer_fwd_lookup.sv | 45 ++++
 rtl/wb_retire_buffer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_buffer_pkg.sv
// ============================================================================
// Module   : wb_retire_buffer_pkg
// Purpose  : Shared exception-bus layout, ecode table and retire-entry format
//            for wb_retire_buffer (optional trace: WB_RETIRE_DEBUG_TRACE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_retire_buffer_pkg;

    // Exception-bus bit positions; a lower index wins when several are set.
    localparam int EBUS_INT  = 0;
    localparam int EBUS_ADEF = 1;
    localparam int EBUS_TLBR = 2;
    localparam int EBUS_PIF  = 3;
    localparam int EBUS_PPI  = 4;
    localparam int EBUS_ALE  = 5;
    localparam int EBUS_ADEM = 6;
    localparam int EBUS_PIL  = 7;
    localparam int EBUS_PIS  = 8;
    localparam int EBUS_PME  = 9;
    localparam int EBUS_SYS  = 10;
    localparam int EBUS_BRK  = 11;
    localparam int EBUS_INE  = 12;
    localparam int EBUS_IPE  = 13;
    localparam int EBUS_FPD  = 14;
    localparam int EBUS_FPE  = 15;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_FPD  = 6'h0F;
    localparam logic [5:0] ECODE_FPE  = 6'h12;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    // Exceptions are decoded on enqueue, so an entry carries ecode/esubcode
    // instead of the raw bus.
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic        res_from_csr;
        logic [13:0] csr_num;
        logic        exc;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
        logic        ertn;
        logic        refetch;
    } retire_entry_t;

    localparam int ENTRY_W = $bits(retire_entry_t);

    function automatic logic [5:0] ebus_ecode(input int idx);
        case (idx)
            EBUS_INT:  return ECODE_INT;
            EBUS_ADEF: return ECODE_ADE;
            EBUS_TLBR: return ECODE_TLBR;
            EBUS_PIF:  return ECODE_PIF;
            EBUS_PPI:  return ECODE_PPI;
            EBUS_ALE:  return ECODE_ALE;
            EBUS_ADEM: return ECODE_ADE;
            EBUS_PIL:  return ECODE_PIL;
            EBUS_PIS:  return ECODE_PIS;
            EBUS_PME:  return ECODE_PME;
            EBUS_SYS:  return ECODE_SYS;
            EBUS_BRK:  return ECODE_BRK;
            EBUS_INE:  return ECODE_INE;
            EBUS_IPE:  return ECODE_IPE;
            EBUS_FPD:  return ECODE_FPD;
            EBUS_FPE:  return ECODE_FPE;
            default:   return 6'h00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_retire_buffer_fwd_lookup.sv
// ============================================================================
// Module   : wb_fwd_lookup
// Purpose  : One forwarding port: youngest matching pending GR write wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fwd_lookup #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]                 cand,
    input  logic [$clog2(DEPTH)-1:0]         head,
    input  logic [DEPTH-1:0][4:0]            waddr,
    input  logic [DEPTH-1:0][31:0]           result,
    input  logic [DEPTH-1:0]                 from_csr,
    input  logic [4:0]                       raddr,
    output logic                             hit,
    output logic                             csr_wait,
    output logic [31:0]                      data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest from the head; a later match overrides, so the
    // youngest pending writer is the one left standing.
    always_comb begin
        hit      = 1'b0;
        csr_wait = 1'b0;
        data     = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head + PTR_W'(k);
            if (cand[w_idx] && (waddr[w_idx] == raddr) && (raddr != 5'd0)) begin
                hit      = 1'b1;
                csr_wait = from_csr[w_idx];
                data     = from_csr[w_idx] ? 32'd0 : result[w_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_retire_buffer.sv
// ============================================================================
// Module   : wb_retire_buffer
// Purpose  : DEPTH-entry in-order retire FIFO with multi-port forwarding.
//            Define WB_RETIRE_DEBUG_TRACE_EN to drive the debug_wb_* trace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_retire_buffer
    import wb_retire_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int EBUS_W  = 16,
    parameter int NUM_FWD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic                  in_rf_we,
    input  logic [4:0]            in_rf_waddr,
    input  logic [31:0]           in_result,
    input  logic                  in_res_from_csr,
    input  logic [13:0]           in_csr_num,
    input  logic [EBUS_W-1:0]     in_ebus,
    input  logic [31:0]           in_badv,
    input  logic                  in_ertn,
    input  logic                  in_refetch,
    output logic [13:0]           csr_num,
    input  logic [31:0]           csr_rvalue,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    input  logic [5*NUM_FWD-1:0]  fwd_raddr,
    output logic [NUM_FWD-1:0]    fwd_hit,
    output logic [NUM_FWD-1:0]    fwd_csr_wait,
    output logic [32*NUM_FWD-1:0] fwd_data,
    output logic                  except,
    output logic [5:0]            ecode,
    output logic [8:0]            esubcode,
    output logic [31:0]           ex_pc,
    output logic [31:0]           ex_badv,
    output logic                  ertn_flush,
    output logic                  refetch_flush,
    output logic [31:0]           refetch_pc,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0]      r_mem [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;

    retire_entry_t           w_ent [DEPTH];
    retire_entry_t           w_head;
    retire_entry_t           w_new;
    logic [DEPTH-1:0]        w_cand;
    logic [DEPTH-1:0][4:0]   w_waddr;
    logic [DEPTH-1:0][31:0]  w_result;
    logic [DEPTH-1:0]        w_from_csr;
    logic                    w_head_v;
    logic                    w_flush;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_is_exc;
    logic                    w_is_ref;
    logic                    w_wr;

    always_comb begin
        w_new              = '0;
        w_new.pc           = in_pc;
        w_new.rf_we        = in_rf_we;
        w_new.waddr        = in_rf_waddr;
        w_new.result       = in_result;
        w_new.res_from_csr = in_res_from_csr;
        w_new.csr_num      = in_csr_num;
        w_new.exc          = |in_ebus;
        w_new.badv         = in_badv;
        w_new.ertn         = in_ertn;
        w_new.refetch      = in_refetch;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = EBUS_W - 1; i >= 0; i--) begin
            if (in_ebus[i]) begin
                w_new.ecode    = ebus_ecode(i);
                w_new.esubcode = (i == EBUS_ADEM) ? ESUBCODE_ADEM : 9'd0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ent[i]      = retire_entry_t'(r_mem[i]);
            w_cand[i]     = r_valid[i] & ~reset & w_ent[i].rf_we
                            & ~w_ent[i].exc & ~w_ent[i].refetch;
            w_waddr[i]    = w_ent[i].waddr;
            w_result[i]   = w_ent[i].result;
            w_from_csr[i] = w_ent[i].res_from_csr;
        end
    end

    assign w_head   = w_ent[r_head];
    assign w_head_v = r_valid[r_head] & ~reset;
    assign w_flush  = w_head_v & (w_head.refetch | w_head.exc | w_head.ertn);
    assign in_ready = ~reset & (r_count < CNT_W'(DEPTH)) & ~w_flush;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_head_v;

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_new;
        end
    end

    // Retire classification: refetch > exception > ertn > normal.
    assign w_is_ref   = w_head_v & w_head.refetch;
    assign w_is_exc   = w_head_v & ~w_head.refetch & w_head.exc;
    assign ertn_flush = w_head_v & ~w_head.refetch & ~w_head.exc & w_head.ertn;
    assign w_wr       = w_head_v & ~w_head.refetch & ~w_head.exc & w_head.rf_we;

    assign refetch_flush = w_is_ref;
    assign refetch_pc    = w_is_ref ? w_head.pc : 32'd0;
    assign except        = w_is_exc;
    assign ecode         = w_is_exc ? w_head.ecode : 6'd0;
    assign esubcode      = w_is_exc ? w_head.esubcode : 9'd0;
    assign ex_pc         = w_is_exc ? w_head.pc : 32'd0;
    assign ex_badv       = w_is_exc ? w_head.badv : 32'd0;
    assign csr_num       = w_head_v ? w_head.csr_num : 14'd0;
    assign rf_we         = w_wr;
    assign rf_waddr      = w_wr ? w_head.waddr : 5'd0;
    assign rf_wdata      = w_wr ? (w_head.res_from_csr ? csr_rvalue : w_head.result) : 32'd0;

    for (genvar p = 0; p < NUM_FWD; p++) begin : g_fwd
        wb_fwd_lookup #(
            .DEPTH    (DEPTH)
        ) u_lookup (
            .cand     (w_cand),
            .head     (r_head),
            .waddr    (w_waddr),
            .result   (w_result),
            .from_csr (w_from_csr),
            .raddr    (fwd_raddr[5*p +: 5]),
            .hit      (fwd_hit[p]),
            .csr_wait (fwd_csr_wait[p]),
            .data     (fwd_data[32*p +: 32])
        );
    end

`ifdef WB_RETIRE_DEBUG_TRACE_EN
    assign debug_wb_pc       = w_head_v ? w_head.pc : 32'd0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    assign debug_wb_pc       = 32'd0;
    assign debug_wb_rf_we    = 4'd0;
    assign debug_wb_rf_wnum  = 5'd0;
    assign debug_wb_rf_wdata = 32'd0;
`endif

endmodule

`default_nettype wire
